// File: rtl/amplitude_writeback.sv
`default_nettype none
// ----------------------------------------------------------------------------
// amplitude_writeback: buffers updated amplitudes, prunes near-zero terms and
// writes survivors to the amplitude RAM, reporting per-gate term count. rev 1.0
// ----------------------------------------------------------------------------
module amplitude_writeback #(
  parameter int NUM_QUBIT   = 4,
  parameter int COMPLEX_BIT = 24,
  parameter int FP_BIT      = 22,
  parameter int FIFO_DEPTH  = 4,
  parameter int PRUNE_LSB   = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [2*COMPLEX_BIT-1:0]   in_amplitude_i,
  input  logic [NUM_QUBIT-1:0]       in_basis_index_i,
  input  logic                       in_last_i,
  output logic                       ram_write_en_o,
  input  logic                       ram_ready_i,
  output logic [NUM_QUBIT-1:0]       ram_write_addr_o,
  output logic [2*COMPLEX_BIT-1:0]   ram_write_data_o,
  output logic [NUM_QUBIT-1:0]       ram_write_basis_o,
  output logic                       gate_done_o,
  output logic [NUM_QUBIT:0]         num_terms_o,
  output logic                       overflow_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = 2 * COMPLEX_BIT;
  localparam int EW = DW + NUM_QUBIT + 2;
  localparam logic [NUM_QUBIT:0] MAX_TERMS = {1'b1, {NUM_QUBIT{1'b0}}};

  if (FP_BIT > COMPLEX_BIT) begin : g_fp_check
    $error("FP_BIT must not exceed COMPLEX_BIT");
  end

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ACTIVE = 2'd1, S_DONE = 2'd2} state_t;

  state_t                 state_q, state_d;
  logic [EW-1:0]          mem_q [FIFO_DEPTH];
  logic [AW:0]            wr_ptr_q, rd_ptr_q;
  logic                   en_q, en_d, last_q, last_d;
  logic [NUM_QUBIT-1:0]   addr_q, addr_d, basis_q, basis_d;
  logic [DW-1:0]          data_q, data_d;
  logic [NUM_QUBIT:0]     cnt_q, cnt_d, num_terms_q, num_terms_d;
  logic                   ovf_q, ovf_d;

  // A value is prunable when every bit from PRUNE_LSB upward is a sign copy.
  logic [COMPLEX_BIT-1:PRUNE_LSB] re_hi, im_hi;
  logic                   in_zero;
  assign re_hi   = in_amplitude_i[DW-1:COMPLEX_BIT+PRUNE_LSB];
  assign im_hi   = in_amplitude_i[COMPLEX_BIT-1:PRUNE_LSB];
  assign in_zero = ((&re_hi) | ~(|re_hi)) & ((&im_hi) | ~(|im_hi));

  logic                   empty, full, push, accept, free, pop;
  logic                   out_done, head_ends, load, drop, pop_done, done;
  logic [EW-1:0]          head;
  logic                   head_last, head_zero;
  logic [NUM_QUBIT-1:0]   head_basis;
  logic [DW-1:0]          head_amp;
  logic [NUM_QUBIT:0]     base;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
  assign push  = in_valid_i && !full;

  assign head       = mem_q[rd_ptr_q[AW-1:0]];
  assign head_last  = head[EW-1];
  assign head_zero  = head[EW-2];
  assign head_basis = head[DW +: NUM_QUBIT];
  assign head_amp   = head[DW-1:0];

  assign accept   = en_q && ram_ready_i;
  assign free     = !en_q || ram_ready_i;
  assign out_done = accept && last_q;
  // Terms popped in the same cycle the previous gate's last write retires
  // already belong to the next gate and therefore count from zero.
  assign base      = out_done ? '0 : cnt_q;
  assign head_ends = head_last && (head_zero || base == MAX_TERMS);
  // Hold back a gate-ending discard for one cycle so two gates never finish together.
  assign pop      = !empty && free && !(out_done && head_ends);
  assign load     = pop && !head_zero && (base != MAX_TERMS);
  assign drop     = pop && !head_zero && (base == MAX_TERMS);
  assign pop_done = pop && head_last && !load;
  assign done     = out_done || pop_done;

  always_comb begin
    en_d    = en_q;
    addr_d  = addr_q;
    data_d  = data_q;
    basis_d = basis_q;
    last_d  = last_q;
    if (load) begin
      en_d    = 1'b1;
      addr_d  = base[NUM_QUBIT-1:0];
      data_d  = head_amp;
      basis_d = head_basis;
      last_d  = head_last;
    end else if (accept) begin
      en_d = 1'b0;
    end
  end

  always_comb begin
    cnt_d       = pop_done ? '0 : base + (NUM_QUBIT+1)'(load);
    num_terms_d = done ? cnt_q : num_terms_q;
    ovf_d       = ((state_q == S_DONE) ? 1'b0 : ovf_q) | drop;
  end

  always_comb begin
    state_d = state_q;
    if (done) begin
      state_d = S_DONE;
    end else begin
      case (state_q)
        S_IDLE:   if (push) state_d = S_ACTIVE;
        S_ACTIVE: state_d = S_ACTIVE;
        S_DONE:   state_d = (!empty || push || en_d) ? S_ACTIVE : S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_last_i, in_zero, in_basis_index_i, in_amplitude_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      en_q        <= 1'b0;
      last_q      <= 1'b0;
      addr_q      <= '0;
      data_q      <= '0;
      basis_q     <= '0;
      cnt_q       <= '0;
      num_terms_q <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_q + (AW+1)'(push);
      rd_ptr_q    <= rd_ptr_q + (AW+1)'(pop);
      en_q        <= en_d;
      last_q      <= last_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      basis_q     <= basis_d;
      cnt_q       <= cnt_d;
      num_terms_q <= num_terms_d;
      ovf_q       <= ovf_d;
    end
  end

  assign in_ready_o        = !full;
  assign ram_write_en_o    = en_q;
  assign ram_write_addr_o  = addr_q;
  assign ram_write_data_o  = data_q;
  assign ram_write_basis_o = basis_q;
  assign gate_done_o       = (state_q == S_DONE);
  assign num_terms_o       = num_terms_q;
  assign overflow_o        = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_amplitude_writeback.sv
`default_nettype none
// Bench for amplitude_writeback: directed scenarios plus randomized traffic
// checked against a per-gate queue model of expected RAM writes and gate reports.
`timescale 1ns/1ps
module tb_amplitude_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready_o;
  logic [47:0] in_amplitude = '0;
  logic [3:0]  in_basis_index = '0;
  logic        in_last = 1'b0;
  logic        ram_write_en_o;
  logic        ram_ready = 1'b0;
  logic [3:0]  ram_write_addr_o;
  logic [47:0] ram_write_data_o;
  logic [3:0]  ram_write_basis_o;
  logic        gate_done_o;
  logic [4:0]  num_terms_o;
  logic        overflow_o;

  amplitude_writeback dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .in_amplitude_i(in_amplitude), .in_basis_index_i(in_basis_index), .in_last_i(in_last),
    .ram_write_en_o(ram_write_en_o), .ram_ready_i(ram_ready),
    .ram_write_addr_o(ram_write_addr_o), .ram_write_data_o(ram_write_data_o),
    .ram_write_basis_o(ram_write_basis_o), .gate_done_o(gate_done_o),
    .num_terms_o(num_terms_o), .overflow_o(overflow_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [47:0] amp; logic [3:0] basis; logic last; } term_t;
  typedef struct packed { logic [3:0] addr; logic [47:0] amp; logic [3:0] basis; } wr_t;
  typedef struct packed { logic [4:0] n; logic ovf; } gd_t;

  term_t stim[$];
  wr_t   exp_wr[$];
  gd_t   exp_gd[$];
  int    wr_cyc[$];
  int    gd_cyc[$];

  int checks = 0, failures = 0;
  int cyc = 0, npush = 0, nwr = 0, ngd = 0, last_push_cyc = 0;
  int valid_pct = 100;
  bit rdy_rand = 1'b0;
  int m_cnt = 0;
  bit m_ovf = 1'b0;
  logic        prev_en = 1'b0, prev_rdy = 1'b0, prev_gd = 1'b0;
  logic [3:0]  prev_addr = '0, prev_basis = '0;
  logic [47:0] prev_data = '0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference rule: a component is prunable when it lies in [-256, 255].
  function automatic bit is_zero(logic [47:0] a);
    int re, im;
    re = $signed(a[47:24]);
    im = $signed(a[23:0]);
    return (re >= -256 && re <= 255 && im >= -256 && im <= 255);
  endfunction

  task automatic model_push(term_t t);
    wr_t w;
    gd_t g;
    if (!is_zero(t.amp)) begin
      if (m_cnt < 16) begin
        w.addr = m_cnt[3:0]; w.amp = t.amp; w.basis = t.basis;
        exp_wr.push_back(w);
        m_cnt++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    if (t.last) begin
      g.n = m_cnt[4:0]; g.ovf = m_ovf;
      exp_gd.push_back(g);
      m_cnt = 0; m_ovf = 1'b0;
    end
  endtask

  task automatic clear_model();
    stim.delete(); exp_wr.delete(); exp_gd.delete();
    m_cnt = 0; m_ovf = 1'b0;
    prev_en = 1'b0; prev_rdy = 1'b0; prev_gd = 1'b0;
  endtask

  // Entered and left at a falling edge; drives, checks, then steps one cycle.
  task automatic tick();
    wr_t w;
    gd_t g;
    if (stim.size() > 0 && $urandom_range(99) < valid_pct) begin
      in_valid = 1'b1;
      in_amplitude = stim[0].amp; in_basis_index = stim[0].basis; in_last = stim[0].last;
    end else begin
      in_valid = 1'b0;
    end
    if (rdy_rand) ram_ready = ($urandom_range(99) < 65);
    #1;
    if (prev_en && !prev_rdy) begin
      chk("hold_en", ram_write_en_o, 1'b1);
      chk("hold_addr", ram_write_addr_o, prev_addr);
      chk("hold_data", ram_write_data_o, prev_data);
      chk("hold_basis", ram_write_basis_o, prev_basis);
    end
    if (prev_gd) chk("ovf_clear", overflow_o, 1'b0);
    if (ram_write_en_o && ram_ready) begin
      nwr++; wr_cyc.push_back(cyc);
      checks++;
      assert (exp_wr.size() > 0) else begin
        failures++;
        $error("FAIL wr_unexpected observed=addr %0d expected=no write", ram_write_addr_o);
      end
      if (exp_wr.size() > 0) begin
        w = exp_wr.pop_front();
        chk("wr_addr", ram_write_addr_o, w.addr);
        chk("wr_data", ram_write_data_o, w.amp);
        chk("wr_basis", ram_write_basis_o, w.basis);
      end
    end
    if (gate_done_o) begin
      ngd++; gd_cyc.push_back(cyc);
      checks++;
      assert (exp_gd.size() > 0) else begin
        failures++;
        $error("FAIL gd_unexpected observed=num_terms %0d expected=no gate_done", num_terms_o);
      end
      if (exp_gd.size() > 0) begin
        g = exp_gd.pop_front();
        chk("num_terms", num_terms_o, g.n);
        chk("overflow", overflow_o, g.ovf);
      end
    end
    prev_en = ram_write_en_o; prev_rdy = ram_ready; prev_gd = gate_done_o;
    prev_addr = ram_write_addr_o; prev_data = ram_write_data_o; prev_basis = ram_write_basis_o;
    if (in_valid && in_ready_o) begin
      model_push(stim[0]);
      void'(stim.pop_front());
      npush++; last_push_cyc = cyc;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic drain(int bound);
    int n = 0;
    while ((stim.size() > 0 || exp_wr.size() > 0 || exp_gd.size() > 0) && n < bound) begin
      tick(); n++;
    end
    checks++;
    assert (n < bound) else begin
      failures++;
      $error("FAIL drain_timeout observed=%0d cycles expected=<%0d", n, bound);
    end
    repeat (3) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(logic [47:0] amp, logic [3:0] basis, logic last);
    term_t t;
    t.amp = amp; t.basis = basis; t.last = last;
    stim.push_back(t);
  endtask

  function automatic logic [23:0] rnd_comp();
    int v;
    int b[4];
    b[0] = 256; b[1] = -257; b[2] = 255; b[3] = -256;
    case ($urandom_range(3))
      0: v = int'($urandom_range(511)) - 256;
      1: v = b[$urandom_range(3)];
      default: v = int'($urandom);
    endcase
    return v[23:0];
  endfunction

  initial begin
    int c0;
    // Reset state
    @(negedge clk); #1;
    chk("rst_in_ready", in_ready_o, 1'b1);
    chk("rst_en", ram_write_en_o, 1'b0);
    chk("rst_addr", ram_write_addr_o, 4'd0);
    chk("rst_data", ram_write_data_o, 48'd0);
    chk("rst_basis", ram_write_basis_o, 4'd0);
    chk("rst_gd", gate_done_o, 1'b0);
    chk("rst_nterms", num_terms_o, 5'd0);
    chk("rst_ovf", overflow_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Three non-zero terms, consecutive writes, latency check
    rdy_rand = 1'b0; ram_ready = 1'b1; valid_pct = 100;
    wr_cyc.delete(); gd_cyc.delete();
    add({24'h400000, 24'h0}, 4'd1, 1'b0);
    add({24'h400000, 24'h0}, 4'd5, 1'b0);
    add({24'h400000, 24'h0}, 4'd9, 1'b1);
    c0 = cyc;
    drain(50);
    chk("t1_nwrites", wr_cyc.size(), 3);
    if (wr_cyc.size() == 3 && gd_cyc.size() == 1) begin
      chk("t1_latency", wr_cyc[0], c0 + 2);
      chk("t1_consec1", wr_cyc[1], wr_cyc[0] + 1);
      chk("t1_consec2", wr_cyc[2], wr_cyc[1] + 1);
      chk("t1_gd_time", gd_cyc[0], wr_cyc[2] + 1);
    end

    // Pruned term followed by a minimal non-zero term
    add({24'h0000FF, 24'hFFFF80}, 4'd3, 1'b0);
    add({24'h000100, 24'h000000}, 4'd7, 1'b1);
    drain(50);

    // RAM stalled under a 6-term burst
    ram_ready = 1'b0; npush = 0;
    for (int i = 0; i < 6; i++) add({24'h100000 + 24'(i), 24'h7FF000}, 4'(i + 2), (i == 5));
    repeat (10) tick();
    chk("burst_accepted", npush, 5);
    chk("burst_in_ready", in_ready_o, 1'b0);
    chk("burst_en_held", ram_write_en_o, 1'b1);
    ram_ready = 1'b1;
    drain(60);

    // 17 non-zero terms in one gate: overflow
    for (int i = 0; i < 17; i++) add({24'h200000, 24'(i) + 24'h001000}, 4'(i), (i == 16));
    drain(100);
    chk("ovf_after", overflow_o, 1'b0);

    // Back-to-back gates
    ngd = 0;
    add({24'h300000, 24'h0}, 4'd4, 1'b0);
    add({24'h300000, 24'h1}, 4'd6, 1'b1);
    add({24'h300000, 24'h2}, 4'd8, 1'b1);
    drain(50);
    chk("b2b_pulses", ngd, 2);

    // All-pruned gate
    add({24'hFFFF00, 24'h0000FF}, 4'd2, 1'b0);
    add({24'h000000, 24'h000010}, 4'd3, 1'b1);
    drain(50);

    // Randomized traffic
    rdy_rand = 1'b1; valid_pct = 70;
    for (int i = 0; i < 250; i++) add({rnd_comp(), rnd_comp()}, 4'($urandom_range(15)), ($urandom_range(5) == 0) || (i == 249));
    drain(3000);

    // Reset while a write is pending and the FIFO holds 3
    rdy_rand = 1'b0; ram_ready = 1'b0; valid_pct = 100; npush = 0;
    for (int i = 0; i < 4; i++) add({24'h500000, 24'(i)}, 4'(i), 1'b0);
    repeat (6) tick();
    chk("rstmid_pre_en", ram_write_en_o, 1'b1);
    chk("rstmid_pre_full", in_ready_o, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_en", ram_write_en_o, 1'b0);
    chk("rstmid_addr", ram_write_addr_o, 4'd0);
    chk("rstmid_data", ram_write_data_o, 48'd0);
    chk("rstmid_basis", ram_write_basis_o, 4'd0);
    chk("rstmid_in_ready", in_ready_o, 1'b1);
    chk("rstmid_gd", gate_done_o, 1'b0);
    chk("rstmid_nterms", num_terms_o, 5'd0);
    chk("rstmid_ovf", overflow_o, 1'b0);
    clear_model();
    @(negedge clk);
    rst_n = 1'b1; ram_ready = 1'b1; nwr = 0; ngd = 0;
    repeat (10) tick();
    chk("rstmid_no_wr", nwr, 0);
    chk("rstmid_no_gd", ngd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
